// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: the processor port has fixed priority, and the debug/loader port is
// served on idle processor cycles or by a forced one-cycle processor stall.
module dmem_arbiter #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4,
   localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
   input  logic              clock,
   input  logic              reset,
   // processor port
   input  logic              p_req,
   input  logic              p_wren,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_data,
   output logic [DATA_W-1:0] p_q,
   output logic              p_stall,
   // debug port: d_req, d_wren, d_addr and d_data are held stable until d_ack pulses
   input  logic              d_req,
   input  logic              d_wren,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_data,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_q,
   // RAM side
   output logic              ram_wEn,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dataIn,
   input  logic [DATA_W-1:0] ram_dataOut,
   // FSM observation
   output logic [1:0]        o_dbg_state,
   output logic [CNT_W-1:0]  o_dbg_cnt
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WAIT);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_own_raw;
   logic             w_dbg_own;

   always_comb begin
      w_own_raw = 1'b0;
      case (r_state)
         S_IDLE:  w_own_raw = d_req & ~p_req;
         S_WAIT:  w_own_raw = ~p_req | (r_cnt == C_MAX);
         default: w_own_raw = 1'b0;
      endcase
   end

   // While reset is held the RAM must stay with the processor, even though the
   // IDLE ownership term would otherwise follow a live d_req.
   assign w_dbg_own = w_own_raw & reset;

   assign p_stall = w_dbg_own & p_req;

   always_comb begin
      if (w_dbg_own) begin
         ram_addr   = d_addr;
         ram_wEn    = d_wren;
         ram_dataIn = d_data;
      end else begin
         ram_addr   = p_addr;
         ram_wEn    = p_wren & p_req & ~p_stall;
         ram_dataIn = p_data;
      end
   end

   assign p_q   = ram_dataOut;
   assign d_ack = (r_state == S_RESP);
   assign d_q   = d_ack ? ram_dataOut : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_dbg_own) begin
               w_state_nxt = S_RESP;
               w_cnt_nxt   = '0;
            end else if (d_req & p_req) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (w_dbg_own) begin
               w_state_nxt = S_RESP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_RESP: begin
            // d_req is ignored here; a still-high request is taken afresh in IDLE
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign o_dbg_state = r_state;
   assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a synchronous RAM model behind the arbiter, cycle-by-cycle
// scenario tasks, and an expected-read-data queue checked on each d_ack.
module tb_dmem_arbiter;

   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic              clock;
   logic              reset;
   logic              p_req, p_wren;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_data, p_q;
   logic              p_stall;
   logic              d_req, d_wren;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_data, d_q;
   logic              d_ack;
   logic              ram_wEn;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dataIn, ram_dataOut;
   logic [1:0]        dbg_state;
   logic [CNT_W-1:0]  dbg_cnt;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] exp_d;

   int n_checks = 0;
   int n_errors = 0;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset),
      .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
      .p_q(p_q), .p_stall(p_stall),
      .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_data(d_data),
      .d_ack(d_ack), .d_q(d_q),
      .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
      .ram_dataOut(ram_dataOut),
      .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // synchronous single-port RAM, read-before-write
   always @(posedge clock) begin
      if (ram_wEn) mem[ram_addr] <= ram_dataIn;
      ram_dataOut <= mem[ram_addr];
   end

   // debug request fields must stay stable until acknowledged
   logic              prev_req, prev_wren;
   logic [ADDR_W-1:0] prev_addr;
   logic [DATA_W-1:0] prev_data;
   always @(posedge clock) begin
      if (reset && prev_req && d_req && !d_ack)
         assert (d_addr == prev_addr && d_data == prev_data && d_wren == prev_wren)
            else $error("illegal debug request change while pending");
      prev_req  <= d_req;
      prev_wren <= d_wren;
      prev_addr <= d_addr;
      prev_data <= d_data;
   end

   task automatic test_reset();
      reset = 1'b0;
      p_req = 1'b0; p_wren = 1'b0; p_addr = 12'h123; p_data = 32'h0;
      d_req = 1'b1; d_wren = 1'b1; d_addr = 12'h0AB; d_data = 32'h1111_2222;
      @(negedge clock); @(negedge clock); #1;
      n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
      n_checks++; if (dbg_cnt !== '0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", dbg_cnt); end
      n_checks++; if (d_ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack: got %b want 0", d_ack); end
      n_checks++; if (p_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", p_stall); end
      n_checks++; if (ram_addr !== 12'h123) begin n_errors++; $display("FAIL reset_mux_addr: got %h want 123", ram_addr); end
      n_checks++; if (ram_wEn !== 1'b0) begin n_errors++; $display("FAIL reset_mux_wen: got %b want 0", ram_wEn); end
      n_checks++; if (d_q !== '0) begin n_errors++; $display("FAIL reset_dq: got %h want 0", d_q); end
      d_req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_idle_write_read();
      @(negedge clock);
      p_req = 1'b0;
      d_req = 1'b1; d_wren = 1'b1; d_addr = 12'h010; d_data = 32'hDEAD_BEEF;
      #1;
      n_checks++; if (ram_wEn !== 1'b1) begin n_errors++; $display("FAIL idle_wr_wen: got %b want 1", ram_wEn); end
      n_checks++; if (ram_addr !== 12'h010) begin n_errors++; $display("FAIL idle_wr_addr: got %h want 010", ram_addr); end
      n_checks++; if (ram_dataIn !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL idle_wr_data: got %h want deadbeef", ram_dataIn); end
      n_checks++; if (d_ack !== 1'b0) begin n_errors++; $display("FAIL idle_wr_early_ack: got %b want 0", d_ack); end
      @(negedge clock);
      d_req = 1'b0;
      #1;
      n_checks++; if (d_ack !== 1'b1) begin n_errors++; $display("FAIL idle_wr_ack: got %b want 1", d_ack); end
      n_checks++; if (mem[12'h010] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL idle_wr_commit: got %h want deadbeef", mem[12'h010]); end
      // read it back
      @(negedge clock);
      d_req = 1'b1; d_wren = 1'b0; d_data = 32'h0;
      exp_q.push_back(32'hDEAD_BEEF);
      #1;
      n_checks++; if (ram_wEn !== 1'b0) begin n_errors++; $display("FAIL idle_rd_wen: got %b want 0", ram_wEn); end
      n_checks++; if (d_ack !== 1'b0) begin n_errors++; $display("FAIL idle_rd_early_ack: got %b want 0", d_ack); end
      @(negedge clock);
      d_req = 1'b0;
      #1;
      n_checks++; if (d_ack !== 1'b1) begin n_errors++; $display("FAIL idle_rd_ack: got %b want 1", d_ack); end
      exp_d = exp_q.pop_front();
      n_checks++; if (d_q !== exp_d) begin n_errors++; $display("FAIL idle_rd_dq: got %h want %h", d_q, exp_d); end
   endtask

   task automatic test_busy_forced();
      logic [1:0] es;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         p_req = 1'b1; p_wren = 1'b1; p_addr = 12'h020;
         p_data = (k <= 5) ? (32'h1000 + k) : 32'h1005;
         if (k == 1) begin
            d_req = 1'b1; d_wren = 1'b0; d_addr = 12'h010; d_data = 32'h0;
            exp_q.push_back(32'hDEAD_BEEF);
         end
         if (k == 6) d_req = 1'b0;
         #1;
         es = (k == 1) ? IDLE : (k <= 5) ? WAIT : RESP;
         n_checks++; if (dbg_state !== es) begin n_errors++; $display("FAIL busy_state k=%0d: got %0d want %0d", k, dbg_state, es); end
         if (k >= 2 && k <= 5) begin
            n_checks++; if (dbg_cnt !== CNT_W'(k - 1)) begin n_errors++; $display("FAIL busy_cnt k=%0d: got %0d want %0d", k, dbg_cnt, k - 1); end
         end
         n_checks++; if (p_stall !== (k == 5)) begin n_errors++; $display("FAIL busy_stall k=%0d: got %b want %b", k, p_stall, k == 5); end
         n_checks++; if (ram_wEn !== (k != 5)) begin n_errors++; $display("FAIL busy_wen k=%0d: got %b want %b", k, ram_wEn, k != 5); end
         n_checks++; if (ram_addr !== ((k == 5) ? 12'h010 : 12'h020)) begin n_errors++; $display("FAIL busy_addr k=%0d: got %h", k, ram_addr); end
         n_checks++; if (d_ack !== (k == 6)) begin n_errors++; $display("FAIL busy_ack k=%0d: got %b want %b", k, d_ack, k == 6); end
         if (k == 6) begin
            exp_d = exp_q.pop_front();
            n_checks++; if (d_q !== exp_d) begin n_errors++; $display("FAIL busy_dq: got %h want %h", d_q, exp_d); end
            n_checks++; if (mem[12'h020] !== 32'h1004) begin n_errors++; $display("FAIL busy_stalled_not_committed: got %h want 00001004", mem[12'h020]); end
         end
      end
      @(negedge clock);
      p_req = 1'b0; p_wren = 1'b0;
      #1;
      n_checks++; if (mem[12'h020] !== 32'h1005) begin n_errors++; $display("FAIL busy_resume_commit: got %h want 00001005", mem[12'h020]); end
   endtask

   task automatic test_busy_then_idle();
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         p_req = (k <= 2); p_wren = 1'b0; p_addr = 12'h050;
         if (k == 1) begin
            d_req = 1'b1; d_wren = 1'b0; d_addr = 12'h020; d_data = 32'h0;
            exp_q.push_back(32'h1005);
         end
         if (k == 4) d_req = 1'b0;
         #1;
         n_checks++; if (p_stall !== 1'b0) begin n_errors++; $display("FAIL bti_stall k=%0d: got %b want 0", k, p_stall); end
         n_checks++; if (ram_addr !== ((k == 3) ? 12'h020 : 12'h050)) begin n_errors++; $display("FAIL bti_addr k=%0d: got %h", k, ram_addr); end
         n_checks++; if (d_ack !== (k == 4)) begin n_errors++; $display("FAIL bti_ack k=%0d: got %b want %b", k, d_ack, k == 4); end
         if (k == 4) begin
            exp_d = exp_q.pop_front();
            n_checks++; if (d_q !== exp_d) begin n_errors++; $display("FAIL bti_dq: got %h want %h", d_q, exp_d); end
         end
      end
   endtask

   task automatic test_simultaneous();
      @(negedge clock);
      p_req = 1'b1; p_wren = 1'b1; p_addr = 12'h030; p_data = 32'd7;
      d_req = 1'b1; d_wren = 1'b0; d_addr = 12'h030; d_data = 32'h0;
      exp_q.push_back(32'd7);
      #1;
      n_checks++; if (ram_wEn !== 1'b1 || ram_dataIn !== 32'd7) begin n_errors++; $display("FAIL sim_proc_owns: wen=%b data=%h want 1/7", ram_wEn, ram_dataIn); end
      n_checks++; if (p_stall !== 1'b0) begin n_errors++; $display("FAIL sim_stall: got %b want 0", p_stall); end
      @(negedge clock);
      p_req = 1'b0; p_wren = 1'b0;
      #1;
      n_checks++; if (dbg_state !== WAIT || dbg_cnt !== CNT_W'(1)) begin n_errors++; $display("FAIL sim_wait: state=%0d cnt=%0d want 1/1", dbg_state, dbg_cnt); end
      n_checks++; if (ram_wEn !== 1'b0) begin n_errors++; $display("FAIL sim_grant_wen: got %b want 0", ram_wEn); end
      @(negedge clock);
      d_req = 1'b0;
      #1;
      n_checks++; if (d_ack !== 1'b1) begin n_errors++; $display("FAIL sim_ack: got %b want 1", d_ack); end
      exp_d = exp_q.pop_front();
      n_checks++; if (d_q !== exp_d) begin n_errors++; $display("FAIL sim_dq: got %h want %h", d_q, exp_d); end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         p_req = 1'b0; p_wren = 1'b0; p_addr = 12'h0FF;
         d_wren = 1'b1; d_addr = 12'h040; d_data = 32'h55AA_1234;
         d_req = (k <= 3);
         #1;
         n_checks++; if (d_ack !== (k == 2 || k == 4)) begin n_errors++; $display("FAIL b2b_ack k=%0d: got %b", k, d_ack); end
         n_checks++; if (ram_wEn !== (k == 1 || k == 3)) begin n_errors++; $display("FAIL b2b_wen k=%0d: got %b", k, ram_wEn); end
         if (k == 2) begin
            n_checks++; if (ram_addr !== 12'h0FF) begin n_errors++; $display("FAIL b2b_resp_mux: got %h want 0ff", ram_addr); end
         end
         if (k == 3) begin
            n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL b2b_idle: got %0d want %0d", dbg_state, IDLE); end
         end
      end
      n_checks++; if (mem[12'h040] !== 32'h55AA_1234) begin n_errors++; $display("FAIL b2b_commit: got %h", mem[12'h040]); end
   endtask

   task automatic test_reset_mid();
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         p_req = 1'b1; p_wren = 1'b0; p_addr = 12'h060;
         d_req = 1'b1; d_wren = 1'b0; d_addr = 12'h070; d_data = 32'h0;
      end
      #1;
      n_checks++; if (dbg_state !== WAIT || dbg_cnt !== CNT_W'(2)) begin n_errors++; $display("FAIL rst_mid_pre: state=%0d cnt=%0d want 1/2", dbg_state, dbg_cnt); end
      reset = 1'b0;
      d_req = 1'b0;
      #1;
      n_checks++; if (dbg_state !== IDLE || dbg_cnt !== '0) begin n_errors++; $display("FAIL rst_mid_state: state=%0d cnt=%0d want 0/0", dbg_state, dbg_cnt); end
      n_checks++; if (d_ack !== 1'b0 || p_stall !== 1'b0) begin n_errors++; $display("FAIL rst_mid_outs: ack=%b stall=%b want 0/0", d_ack, p_stall); end
      n_checks++; if (ram_addr !== 12'h060) begin n_errors++; $display("FAIL rst_mid_mux: got %h want 060", ram_addr); end
      @(negedge clock);
      reset = 1'b1;
      p_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock); #1;
         n_checks++; if (d_ack !== 1'b0) begin n_errors++; $display("FAIL rst_mid_no_ack c=%0d: got %b want 0", k, d_ack); end
      end
   endtask

   initial begin
      test_reset();
      test_idle_write_read();
      test_busy_forced();
      test_busy_then_idle();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
